// File: rtl/slave_mult_rq_ack.sv
// Sequential shift-and-add multiplier, slave side of the req/ack handshake.
// Optional build macro START_QUAL_EN: accept only when req & start are both high.
module slave_mult_rq_ack #(
  parameter int REQDATA_WIDTH = 16,
  parameter int ACKDATA_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req,
  input  logic                     start,
  input  logic [REQDATA_WIDTH-1:0] req_data,
  output logic                     ack,
  output logic [ACKDATA_WIDTH-1:0] ack_data,
  output logic                     busy
);

  localparam int W     = REQDATA_WIDTH / 2;
  localparam int PW    = 2 * W;
  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [PW-1:0]            a_q, a_d;
  logic [W-1:0]             b_q, b_d;
  logic [PW-1:0]            p_q, p_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     ack_d;
  logic [ACKDATA_WIDTH-1:0] ack_data_d;
  logic                     busy_d;

  logic                     accept;
  logic [PW-1:0]            p_sum;
  logic [ACKDATA_WIDTH-1:0] ack_res;

`ifdef START_QUAL_EN
  assign accept = req & start;
`else
  logic unused_start;
  assign unused_start = start;
  assign accept       = req;
`endif

  // Partial product for this step, so the final edge can publish P including its last addition.
  assign p_sum = b_q[0] ? (p_q + a_q) : p_q;

  if (ACKDATA_WIDTH <= PW) begin : g_trunc
    assign ack_res = p_sum[ACKDATA_WIDTH-1:0];
  end else begin : g_zext
    assign ack_res = ACKDATA_WIDTH'(p_sum);
  end

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    p_d        = p_q;
    cnt_d      = cnt_q;
    ack_d      = 1'b0;
    ack_data_d = ack_data;
    busy_d     = busy;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d     = {{W{1'b0}}, req_data[REQDATA_WIDTH-1:W]};
          b_d     = req_data[W-1:0];
          p_d     = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_CALC;
        end
      end

      S_CALC: begin
        p_d   = p_sum;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          ack_d      = 1'b1;
          ack_data_d = ack_res;
          state_d    = S_DONE;
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      ack      <= 1'b0;
      ack_data <= '0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      p_q      <= p_d;
      cnt_q    <= cnt_d;
      ack      <= ack_d;
      ack_data <= ack_data_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_slave_mult_rq_ack.sv
// Self-checking bench for slave_mult_rq_ack: cycle-level timeline model plus directed
// literal checks and randomized req/start/req_data/reset stimulus.
module tb_slave_mult_rq_ack;

  localparam int RQ  = 16;
  localparam int AK  = 16;
  localparam int W   = RQ / 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req;
  logic          start;
  logic [RQ-1:0] req_data;
  logic          ack;
  logic [AK-1:0] ack_data;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  slave_mult_rq_ack #(
    .REQDATA_WIDTH(RQ),
    .ACKDATA_WIDTH(AK)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .start   (start),
    .req_data(req_data),
    .ack     (ack),
    .ack_data(ack_data),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [AK-1:0] product(input logic [RQ-1:0] d);
    logic [63:0] x;
    logic [63:0] y;
    logic [63:0] p;
    x = 64'(d[RQ-1:W]);
    y = 64'(d[W-1:0]);
    p = x * y;
    return AK'(p);
  endfunction

  // Timeline model: an accept at edge e0 owns the block until e0+W+1; ack at e0+W.
  int            cyc     = 0;
  int            e0      = 0;
  int            next_ok = 0;
  bit            m_valid = 1'b0;
  logic [AK-1:0] pend    = '0;
  logic [AK-1:0] m_ack_data = '0;
  logic          exp_ack  = 1'b0;
  logic          exp_busy = 1'b0;

  always @(posedge clk) begin
    bit acc;
    cyc++;
`ifdef START_QUAL_EN
    acc = req && start;
`else
    acc = req;
`endif
    if (!rst_n) begin
      m_valid    = 1'b0;
      m_ack_data = '0;
      next_ok    = 0;
    end else begin
      if (cyc >= next_ok && acc) begin
        e0      = cyc;
        m_valid = 1'b1;
        pend    = product(req_data);
        next_ok = cyc + W + 2;
      end
      if (m_valid && cyc == e0 + W) m_ack_data = pend;
    end
    exp_ack  = m_valid && (cyc == e0 + W);
    exp_busy = m_valid && (cyc >= e0) && (cyc <= e0 + W);
  end

  always @(posedge clk) begin
    #1;
    check("ack", 32'(ack), 32'(exp_ack));
    check("busy", 32'(busy), 32'(exp_busy));
    check("ack_data", 32'(ack_data), 32'(m_ack_data));
  end

  task automatic wait_ack(input string name, input int bound, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!ack && k < bound);
    check({name, "_ack_seen"}, 32'(ack), 32'd1);
  endtask

  task automatic run_mul(input string name, input logic [RQ-1:0] d, input logic [AK-1:0] exp_p);
    int k;
    req      = 1'b1;
    start    = 1'b1;
    req_data = d;
    wait_ack(name, 30, k);
    check({name, "_latency"}, 32'(k), 32'(W + 1));
    check({name, "_data"}, 32'(ack_data), 32'(exp_p));
    req   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check({name, "_busy_off"}, 32'(busy), 32'd0);
    check({name, "_ack_off"}, 32'(ack), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int k;
    int last;
    int nacks;

    rst_n    = 1'b0;
    req      = 1'b0;
    start    = 1'b0;
    req_data = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(ack_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_mul("m7x10", 16'h070A, 16'h0046);
    run_mul("mffxff", 16'hFFFF, 16'hFE01);
    run_mul("m0xab", 16'h00AB, 16'h0000);

    // Back-to-back with req held high.
    req = 1'b1; start = 1'b1; req_data = 16'h0305;
    last = -1; nacks = 0;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      if (ack) begin
        if (last >= 0) check("b2b_period", 32'(i - last), 32'(W + 2));
        check("b2b_data", 32'(ack_data), 32'h000F);
        last = i;
        nacks++;
      end
    end
    check("b2b_acks", 32'(nacks), 32'd3);
    req = 1'b0; start = 1'b0;
    repeat (12) @(negedge clk);

    // Reset in the middle of a computation.
    req = 1'b1; start = 1'b1; req_data = 16'h070A;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    req   = 1'b0;
    start = 1'b0;
    #1;
    check("midrst_ack", 32'(ack), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_data", 32'(ack_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nacks = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ack) nacks++;
    end
    check("midrst_no_ack", 32'(nacks), 32'd0);
    run_mul("after_rst", 16'h070A, 16'h0046);

    // req dropped and req_data changed during CALC.
    req = 1'b1; start = 1'b1; req_data = 16'h070A;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 2) begin
        req      = 1'b0;
        start    = 1'b0;
        req_data = 16'h0202;
      end
    end while (!ack && k < 30);
    check("drop_latency", 32'(k), 32'(W + 1));
    check("drop_data", 32'(ack_data), 32'h0046);
    repeat (3) @(negedge clk);

    // req high with start low.
    req = 1'b1; start = 1'b0; req_data = 16'h070A;
    nacks = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack) nacks++;
    end
`ifdef START_QUAL_EN
    check("qual_no_ack", 32'(nacks), 32'd0);
    check("qual_busy", 32'(busy), 32'd0);
    start = 1'b1;
    wait_ack("qual_go", 30, k);
    check("qual_latency", 32'(k), 32'(W + 1));
    check("qual_data", 32'(ack_data), 32'h0046);
`else
    check("noqual_acks", 32'(nacks), 32'd2);
`endif
    req = 1'b0; start = 1'b0;
    repeat (12) @(negedge clk);

    // Randomized traffic with occasional resets; the model compare covers every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
      req      = ($urandom_range(0, 99) < 70);
      start    = ($urandom_range(0, 99) < 60);
      req_data = RQ'($urandom);
    end
    rst_n = 1'b1;
    req   = 1'b0;
    start = 1'b0;
    repeat (W + 4) @(negedge clk);
    check("final_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/slave_mult_rq_ack.md
# slave_mult_rq_ack

- Sequential shift-and-add multiplier that acts as the slave side of the req/ack handshake.
- Accepts two packed operands on `req_data` while `req` is high.
- Computes the product over W cycles, where W = REQDATA_WIDTH/2.
- Returns the product on `ack_data` with a one-cycle `ack` pulse.
- Sits directly downstream of the request master and consumes its `req`/`start`/`req_data` stream.

## Interface
- REQDATA_WIDTH, 16: request data width. Must be even and ≤32; op1 = req_data[REQDATA_WIDTH-1:W], op2 = req_data[W-1:0].
- ACKDATA_WIDTH, 16: product output width (≤32).
- clk  input  1  clock, active on rising edge.
- rst_n  input  1  asynchronous reset, active low.
- req  input  1  request, active high, level-sampled.
- start  input  1  start qualifier from master; used only with START_QUAL_EN.
- req_data  input  REQDATA_WIDTH  packed operands {op1, op2}.
- ack  output  1  confirmation, one-cycle pulse, active high.
- ack_data  output  ACKDATA_WIDTH  product, registered.
- busy  output  1  high while a multiplication is in progress or being acknowledged.

## Operation
- Reset values:
  - state = IDLE
  - ack = 0, ack_data = 0, busy = 0
  - internal registers A, B, P, cnt cleared
- IDLE:
  - An accept occurs when the accept condition is 1 at a rising edge (E0). The accept condition is `req` alone, or `req & start` with START_QUAL_EN.
  - On accept: A <= zero-extended op1 (2W bits), B <= op2, P <= 0, cnt <= 0, busy <= 1, next state CALC.
  - Otherwise the block stays in IDLE.
- CALC, on each edge:
  - if B[0], then P <= P + A
  - A <= A << 1, B <= B >> 1, cnt <= cnt + 1
  - On the edge where cnt == W-1, go to DONE: ack <= 1 and ack_data <= the final P, including that last addition.
- DONE, for exactly one cycle:
  - next edge: ack <= 0, busy <= 0, state IDLE
- Arithmetic:
  - P is 2W bits unsigned; no overflow is possible.
  - ack_data = P[ACKDATA_WIDTH-1:0] if ACKDATA_WIDTH < 2W, otherwise P zero-extended.
- Operands are captured only at E0. Changes to `req_data`, `req` or `start` during CALC/DONE are ignored.
- Dropping `req` mid-computation does not abort it; the ack is still issued.
- `ack_data` holds its value until the next ack; it is never cleared except by reset.
- Reset asserted mid-operation aborts immediately: no ack, all outputs return to their reset values, state IDLE.

## Timing
- Acceptance edge E0 → ack high from edge E0+W to edge E0+W+1; exactly one cycle. For W = 8, ack is visible in the 9th cycle after E0.
- `ack_data` changes only at the edge where ack rises, and is valid while ack = 1.
- The block is back in IDLE after edge E0+W+1. If `req` is still or again high, the earliest next accept is edge E0+W+2.
- With `req` held permanently high (back-to-back), the accept-to-accept period is W+2 cycles (10 for default widths).
- busy is high from E0 to E0+W+1.
- No combinational path from inputs to outputs.

## Configuration
- START_QUAL_EN:
  - Defined: the accept condition is `req & start`. `req` high with `start` low in IDLE is ignored and the block stays in IDLE.
  - Undefined: the accept condition is `req` alone and `start` is unused.
  - CALC/DONE behaviour is identical in both builds.

## Test plan
- req_data = 0x070A (7×10), req = start = 1 for 2 cycles, req held until ack → single ack pulse at E0+8, ack_data = 0x0046, busy low after E0+9.
- req_data = 0xFFFF → ack_data = 0xFE01 (65025); req_data = 0x00AB → ack_data = 0x0000.
- `req` held high continuously with req_data = 0x0305 → ack every 10 cycles, each time with ack_data = 0x000F.
- rst_n pulsed low at E0+4 during 0x070A → ack never rises, ack_data = 0, busy = 0. A new request after reset completes normally with 0x0046.
- `req` dropped at E0+2 → computation completes and ack still rises at E0+8 with the correct product. `req_data` changed to 0x0202 during CALC → result is still 0x0046.
- START_QUAL_EN defined: req = 1, start = 0 for 20 cycles → no ack, busy = 0; then start = 1 → accept and normal ack after 8 cycles. Without the macro, the same stimulus accepts immediately.
